global_lock_arbiter: RTL
========================

Name: global_lock_arbiter

Overview:
Shared-resource side of the dual-core lock and global-memory protocol. It sits between two tiny_risc_v cores and the shared 64x32 global memory. It receives each core's need_lock request and global-memory port (address, data, write enable). It returns each core's lock stall input and its global read data, arbitrates lock ownership round-robin, gates non-owner writes, and flags over-long lock holds.

Parameters:
ADDR_W, 6, global memory address width (depth 2**ADDR_W words)
DATA_W, 32, global memory word width
HOLD_MAX, 1024, owner hold cycles before lock_timeout is raised

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
need_lock0  input  1  core 0 lock request (level; high = want/hold lock)
need_lock1  input  1  core 1 lock request
gaddress0  input  ADDR_W  core 0 global address
gaddress1  input  ADDR_W  core 1 global address
gdata0  input  DATA_W  core 0 global write data
gdata1  input  DATA_W  core 1 global write data
gwren0  input  1  core 0 global write enable
gwren1  input  1  core 1 global write enable
lock0  output  1  stall to core 0 (high = core 0 must hold state)
lock1  output  1  stall to core 1
gq0  output  DATA_W  registered read data for gaddress0
gq1  output  DATA_W  registered read data for gaddress1
owner_valid  output  1  a core currently owns the lock
owner_id  output  1  owning core index (meaningful when owner_valid)
lock_timeout  output  1  sticky: owner held lock more than HOLD_MAX cycles

Behaviour:
- Reset (rst low, asynchronous): state IDLE; owner_valid=0, owner_id=0, lock0=lock1=0, gq0=gq1=0, lock_timeout=0, hold counter=0, last_grant=1 (so core 0 wins the first tie). Memory contents are not reset.
- FSM states and transitions, evaluated on the rising clk edge:
  - IDLE: need_lock0 & ~need_lock1 -> OWN0.
  - IDLE: need_lock1 & ~need_lock0 -> OWN1.
  - IDLE: both requests high -> the core not equal to last_grant.
  - OWN0: need_lock0 high -> stay OWN0.
  - OWN0: need_lock0 low and need_lock1 high -> OWN1 directly, with no IDLE cycle.
  - OWN0: need_lock0 low and need_lock1 low -> IDLE.
  - OWN1: symmetric to OWN0.
  - On every entry to OWNn, last_grant is set to n.
- Grant latency: one cycle from the edge that samples a request to owner_valid/owner_id being updated.
- Stall outputs are combinational from registered state only: lockN = owner_valid & (owner_id != N). The owner is never stalled. In IDLE neither core is stalled.
- Write gating:
  - Effective weN = gwrenN & ~lockN; a stalled core's write never reaches memory.
  - Both effective writes to the same address in one cycle: core 0's data is stored.
  - Writes to different addresses both commit.
- Reads: gqN <= mem[gaddressN] on every edge (1-cycle latency), read-before-write. Same-cycle write to the same address returns the old word.
- Hold counter:
  - Cleared on every ownership change and in IDLE.
  - Increments each cycle in OWNn and saturates at HOLD_MAX.
  - Reaching HOLD_MAX sets lock_timeout, which stays high until reset. The owner keeps the lock; there is no forced revocation.
- Reset mid-ownership: immediately returns to IDLE and releases both stalls. A core still asserting need_lock is re-granted one cycle after reset deasserts.
- Illegal FSM encoding: return to IDLE.

Decomposition:
- Shared package: state encodings (IDLE, OWN0, OWN1), core index constants, ADDR_W/DATA_W defaults.
- One sub-module, global_mem: 2-read/2-write-port synchronous RAM, read-before-write, port 0 priority on same-address write.
- Arbiter FSM, stall logic and hold counter stay in global_lock_arbiter.

Test Plan:
- Single request: need_lock0=1 from IDLE -> next cycle owner_valid=1, owner_id=0, lock1=1, lock0=0. Drop need_lock0 -> next cycle IDLE, lock1=0.
- Tie: from reset, both requests rise together -> core 0 granted. After core 0 releases with need_lock1 still high -> OWN1 on the next edge (no IDLE), lock0=1.
- Round-robin: after core 1 owns and releases, raise both requests simultaneously -> core 0 granted. After core 0 releases, both high again -> core 1 granted.
- Gating: core 0 owns, core 1 drives gwren1=1, gaddress1=5, gdata1=0xDEADBEEF; core 0 reads address 5 -> gq0 still shows the old value (0x00000000 after a prior clear), write dropped.
- Collision: IDLE, both write address 3 (core0 0x11111111, core1 0x22222222) -> gq0 and gq1 read 0x11111111 the cycle after the read is presented. The same-cycle read returns the previous word.
- Timeout/reset: HOLD_MAX=8, core 0 holds 9 cycles -> lock_timeout=1 and stays set after release. Assert rst during ownership -> lock1 drops asynchronously and all outputs return to reset values.

Source files
------------

// File: rtl/global_lock_arbiter_pkg.sv
// Shared definitions for the dual-core lock arbiter and its global memory.
package global_lock_arbiter_pkg;

  localparam int DEFAULT_ADDR_W = 6;
  localparam int DEFAULT_DATA_W = 32;

  localparam logic CORE0 = 1'b0;
  localparam logic CORE1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } arb_state_t;

  // On a simultaneous request the core that did not win last time goes first.
  function automatic logic tie_winner(input logic last_grant);
    return ~last_grant;
  endfunction

  function automatic arb_state_t own_state(input logic id);
    return id ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/global_lock_arbiter_mem.sv
// Two-port global memory: both ports read and write each cycle.
// Reads are registered and return the word held before any same-edge write.
// When both ports write one address in the same cycle, port 0's data is kept.
module global_mem
  import global_lock_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] q0,
  output logic [DATA_W-1:0] q1
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Port 1 is written first so a colliding port 0 write overrides it.
  always_ff @(posedge clk) begin
    if (we1) mem[addr1] <= wdata1;
    if (we0) mem[addr0] <= wdata0;
  end

  // Registered read ports; only the output registers are reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q0 <= '0;
      q1 <= '0;
    end else begin
      q0 <= mem[addr0];
      q1 <= mem[addr1];
    end
  end

endmodule

// File: rtl/global_lock_arbiter.sv
// Round-robin lock arbiter between two cores sharing a global memory.
// The owning core runs freely; the other core is stalled and its writes are
// dropped. A saturating hold counter flags owners that keep the lock too long.
module global_lock_arbiter
  import global_lock_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int HOLD_MAX = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              need_lock0,
  input  logic              need_lock1,
  input  logic [ADDR_W-1:0] gaddress0,
  input  logic [ADDR_W-1:0] gaddress1,
  input  logic [DATA_W-1:0] gdata0,
  input  logic [DATA_W-1:0] gdata1,
  input  logic              gwren0,
  input  logic              gwren1,
  output logic              lock0,
  output logic              lock1,
  output logic [DATA_W-1:0] gq0,
  output logic [DATA_W-1:0] gq1,
  output logic              owner_valid,
  output logic              owner_id,
  output logic              lock_timeout
);

  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  arb_state_t       state;
  logic             last_grant;
  logic [CNT_W-1:0] hold_cnt;

  logic idle_pick;
  logic owner_keep;
  logic other_req;
  logic other_id;
  logic we0;
  logic we1;

  // With a single requester it wins; with two the round-robin pointer decides.
  assign idle_pick  = (need_lock0 & need_lock1) ? tie_winner(last_grant) : need_lock1;
  assign owner_keep = (state == ST_OWN1) ? need_lock1 : need_lock0;
  assign other_req  = (state == ST_OWN1) ? need_lock0 : need_lock1;
  assign other_id   = (state == ST_OWN1) ? CORE0 : CORE1;

  // Arbiter FSM with registered owner outputs, hold counter and timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      owner_valid  <= 1'b0;
      owner_id     <= CORE0;
      last_grant   <= CORE1;
      hold_cnt     <= '0;
      lock_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          hold_cnt <= '0;
          if (need_lock0 | need_lock1) begin
            state       <= own_state(idle_pick);
            owner_valid <= 1'b1;
            owner_id    <= idle_pick;
            last_grant  <= idle_pick;
          end
        end
        ST_OWN0, ST_OWN1: begin
          if (owner_keep) begin
            if (hold_cnt != HOLD_LIM) hold_cnt <= hold_cnt + CNT_W'(1);
            if (hold_cnt >= HOLD_LAST) lock_timeout <= 1'b1;
          end else if (other_req) begin
            // Hand over directly so the waiting core sees no idle gap.
            state       <= own_state(other_id);
            owner_valid <= 1'b1;
            owner_id    <= other_id;
            last_grant  <= other_id;
            hold_cnt    <= '0;
          end else begin
            state       <= ST_IDLE;
            owner_valid <= 1'b0;
            hold_cnt    <= '0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          owner_valid <= 1'b0;
          hold_cnt    <= '0;
        end
      endcase
    end
  end

  // Stalls depend only on registered ownership; nobody stalls while idle.
  assign lock0 = owner_valid & (owner_id != CORE0);
  assign lock1 = owner_valid & (owner_id != CORE1);

  assign we0 = gwren0 & ~lock0;
  assign we1 = gwren1 & ~lock1;

  global_mem #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we0   (we0),
    .we1   (we1),
    .addr0 (gaddress0),
    .addr1 (gaddress1),
    .wdata0(gdata0),
    .wdata1(gdata1),
    .q0    (gq0),
    .q1    (gq1)
  );

endmodule
